// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit for an N-lane in-order pipeline; shadows EX/MEM/WB destinations.
// Optional FWD_FLAG_EN adds N-flag forwarding (id_setf_i, ex_n_i, n_fwd_o, n_arch_o).
module fwd_scoreboard #(
  parameter  int unsigned LANES  = 2,
  parameter  int unsigned REG_AW = 3,
  parameter  int unsigned NSRC   = 2,
  localparam int unsigned SELW   = $clog2(2 * LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adv_i,
  input  logic                          flush_i,
  input  logic [LANES-1:0]              id_valid_i,
  input  logic [LANES-1:0]              id_wr_i,
  input  logic [LANES-1:0]              id_load_i,
  input  logic [LANES*REG_AW-1:0]       id_rd_i,
  input  logic [LANES*NSRC*REG_AW-1:0]  id_src_i,
  input  logic [LANES*NSRC-1:0]         id_use_i,
  output logic [LANES*NSRC*SELW-1:0]    fwd_sel_o,
  output logic                          stall_o
`ifdef FWD_FLAG_EN
  ,
  input  logic [LANES-1:0]              id_setf_i,
  input  logic [LANES-1:0]              ex_n_i,
  output logic                          n_fwd_o,
  output logic                          n_arch_o
`endif
);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } dst_t;

  dst_t [LANES-1:0]                        ex_d;
  dst_t [LANES-1:0]                        mem_d;
  logic [LANES-1:0][NSRC-1:0][REG_AW-1:0]  ex_src;
  logic [LANES-1:0][NSRC-1:0]              ex_use;
  logic [LANES-1:0]                        wb_v;
  logic [LANES-1:0]                        wb_wr;
  logic [LANES-1:0][REG_AW-1:0]            wb_rd;

  logic [LANES-1:0][NSRC-1:0][REG_AW-1:0]  id_src_a;
  logic [LANES-1:0][NSRC-1:0]              id_use_a;
  logic [LANES-1:0][REG_AW-1:0]            id_rd_a;
  logic [LANES*NSRC-1:0][SELW-1:0]         sel_c;
  logic                                    stall_c;

  assign id_src_a  = id_src_i;
  assign id_use_a  = id_use_i;
  assign id_rd_a   = id_rd_i;
  assign fwd_sel_o = sel_c;
  assign stall_o   = stall_c;

  // Stage shadow: flush beats advance; a stalled advance injects a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_d   <= '0;
      mem_d  <= '0;
      ex_src <= '0;
      ex_use <= '0;
      wb_v   <= '0;
      wb_wr  <= '0;
      wb_rd  <= '0;
    end else if (flush_i) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        wb_v[l]    <= mem_d[l].v;
        wb_wr[l]   <= mem_d[l].wr;
        wb_rd[l]   <= mem_d[l].rd;
        ex_d[l].v  <= 1'b0;
        mem_d[l].v <= 1'b0;
      end
    end else if (adv_i) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        wb_v[l]  <= mem_d[l].v;
        wb_wr[l] <= mem_d[l].wr;
        wb_rd[l] <= mem_d[l].rd;
      end
      mem_d <= ex_d;
      if (stall_c) begin
        for (int unsigned l = 0; l < LANES; l++) ex_d[l].v <= 1'b0;
      end else begin
        for (int unsigned l = 0; l < LANES; l++) begin
          ex_d[l].v  <= id_valid_i[l];
          ex_d[l].wr <= id_wr_i[l];
          ex_d[l].ld <= id_load_i[l];
          ex_d[l].rd <= id_rd_a[l];
        end
        ex_src <= id_src_a;
        ex_use <= id_use_a;
      end
    end
  end

  // Bypass select: later loop iterations override, so MEM beats WB and higher lanes win.
  always_comb begin
    sel_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (ex_d[l].v && ex_use[l][s] && (ex_src[l][s] != '0)) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (wb_v[k] && wb_wr[k] && (wb_rd[k] == ex_src[l][s]))
              sel_c[l*NSRC+s] = SELW'(1 + LANES + k);
          end
          for (int unsigned k = 0; k < LANES; k++) begin
            if (mem_d[k].v && mem_d[k].wr && !mem_d[k].ld && (mem_d[k].rd == ex_src[l][s]))
              sel_c[l*NSRC+s] = SELW'(1 + k);
          end
        end
      end
    end
  end

  // Load-use stall: any live ID source that names the destination of a load in EX.
  always_comb begin
    stall_c = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        for (int unsigned e = 0; e < LANES; e++) begin
          if (id_valid_i[i] && id_use_a[i][s] && (id_src_a[i][s] != '0) &&
              ex_d[e].v && ex_d[e].wr && ex_d[e].ld && (ex_d[e].rd == id_src_a[i][s]))
            stall_c = 1'b1;
        end
      end
    end
    if (flush_i) stall_c = 1'b0;
  end

`ifdef FWD_FLAG_EN
  logic [LANES-1:0] ex_setf;
  logic [LANES-1:0] mem_setf;
  logic [LANES-1:0] mem_n;
  logic [LANES-1:0] wb_setf;
  logic [LANES-1:0] wb_n;
  logic             n_arch_q;
  logic             n_fwd_c;

  // Flag shadow follows the destination shadow; architectural N retires from WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_setf  <= '0;
      mem_setf <= '0;
      mem_n    <= '0;
      wb_setf  <= '0;
      wb_n     <= '0;
      n_arch_q <= 1'b0;
    end else if (flush_i || adv_i) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (wb_v[k] && wb_setf[k]) n_arch_q <= wb_n[k];
      end
      wb_setf <= mem_setf;
      wb_n    <= mem_n;
      if (!flush_i) begin
        mem_setf <= ex_setf;
        mem_n    <= ex_n_i;
        if (!stall_c) ex_setf <= id_setf_i;
      end
    end
  end

  always_comb begin
    n_fwd_c = n_arch_q;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (wb_v[k] && wb_setf[k]) n_fwd_c = wb_n[k];
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      if (mem_d[k].v && mem_setf[k]) n_fwd_c = mem_n[k];
    end
  end

  assign n_fwd_o  = n_fwd_c;
  assign n_arch_o = n_arch_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random traffic against a stage-list model.
module tb_fwd_scoreboard;
  localparam int LANES  = 2;
  localparam int REG_AW = 3;
  localparam int NSRC   = 2;
  localparam int SELW   = 3;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         adv_i, flush_i;
  logic [LANES-1:0]             id_valid_i, id_wr_i, id_load_i;
  logic [LANES*REG_AW-1:0]      id_rd_i;
  logic [LANES*NSRC*REG_AW-1:0] id_src_i;
  logic [LANES*NSRC-1:0]        id_use_i;
  logic [LANES*NSRC*SELW-1:0]   fwd_sel_o;
  logic                         stall_o;

  fwd_scoreboard #(.LANES(LANES), .REG_AW(REG_AW), .NSRC(NSRC)) dut (
    .clk(clk), .rst_n(rst_n), .adv_i(adv_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_wr_i(id_wr_i), .id_load_i(id_load_i),
    .id_rd_i(id_rd_i), .id_src_i(id_src_i), .id_use_i(id_use_i),
    .fwd_sel_o(fwd_sel_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ID bundle as the bench sees it
  bit          i_v[LANES], i_wr[LANES], i_ld[LANES];
  int unsigned i_rd[LANES];
  int unsigned i_src[LANES][NSRC];
  bit          i_use[LANES][NSRC];

  // Model: stage 0 = EX, 1 = MEM, 2 = WB
  bit          m_v[3][LANES], m_wr[3][LANES], m_ld[3][LANES];
  int unsigned m_rd[3][LANES];
  int unsigned m_src[LANES][NSRC];
  bit          m_use[LANES][NSRC];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int unsigned dut_sel(input int l, input int s);
    logic [SELW-1:0] v;
    v = fwd_sel_o[(l*NSRC+s)*SELW +: SELW];
    return int'(v);
  endfunction

  // Youngest producer first: MEM lanes high->low (loads excluded), then WB lanes high->low.
  function automatic int unsigned exp_sel(input int l, input int s);
    int unsigned a;
    a = m_src[l][s];
    if (!m_v[0][l] || !m_use[l][s] || a == 0) return 0;
    for (int st = 1; st <= 2; st++)
      for (int k = LANES - 1; k >= 0; k--)
        if (m_v[st][k] && m_wr[st][k] && !(st == 1 && m_ld[st][k]) && m_rd[st][k] == a)
          return 1 + (st - 1) * LANES + k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    if (flush_i) return 0;
    for (int i = 0; i < LANES; i++)
      for (int s = 0; s < NSRC; s++)
        for (int e = 0; e < LANES; e++)
          if (i_v[i] && i_use[i][s] && i_src[i][s] != 0 &&
              m_v[0][e] && m_wr[0][e] && m_ld[0][e] && m_rd[0][e] == i_src[i][s])
            return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int st = 0; st < 3; st++)
      for (int l = 0; l < LANES; l++) m_v[st][l] = 0;
  endtask

  task automatic copy_stage(input int dst, input int src);
    for (int l = 0; l < LANES; l++) begin
      m_v[dst][l] = m_v[src][l]; m_wr[dst][l] = m_wr[src][l];
      m_ld[dst][l] = m_ld[src][l]; m_rd[dst][l] = m_rd[src][l];
    end
  endtask

  task automatic model_clock(input bit st);
    if (flush_i) begin
      copy_stage(2, 1);
      for (int l = 0; l < LANES; l++) begin m_v[1][l] = 0; m_v[0][l] = 0; end
    end else if (adv_i) begin
      copy_stage(2, 1);
      copy_stage(1, 0);
      for (int l = 0; l < LANES; l++) begin
        if (st) m_v[0][l] = 0;
        else begin
          m_v[0][l] = i_v[l]; m_wr[0][l] = i_wr[l]; m_ld[0][l] = i_ld[l]; m_rd[0][l] = i_rd[l];
          for (int s = 0; s < NSRC; s++) begin m_src[l][s] = i_src[l][s]; m_use[l][s] = i_use[l][s]; end
        end
      end
    end
  endtask

  task automatic apply();
    for (int l = 0; l < LANES; l++) begin
      id_valid_i[l] = i_v[l];
      id_wr_i[l]    = i_wr[l];
      id_load_i[l]  = i_ld[l];
      id_rd_i[l*REG_AW +: REG_AW] = REG_AW'(i_rd[l]);
      for (int s = 0; s < NSRC; s++) begin
        id_src_i[(l*NSRC+s)*REG_AW +: REG_AW] = REG_AW'(i_src[l][s]);
        id_use_i[l*NSRC+s] = i_use[l][s];
      end
    end
  endtask

  task automatic clear_id();
    for (int l = 0; l < LANES; l++) begin
      i_v[l] = 0; i_wr[l] = 0; i_ld[l] = 0; i_rd[l] = 0;
      for (int s = 0; s < NSRC; s++) begin i_src[l][s] = 0; i_use[l][s] = 0; end
    end
  endtask

  task automatic set_lane(input int l, input bit wr, input bit ld, input int unsigned rd,
                          input int unsigned s0, input bit u0, input int unsigned s1, input bit u1);
    i_v[l] = 1; i_wr[l] = wr; i_ld[l] = ld; i_rd[l] = rd;
    i_src[l][0] = s0; i_use[l][0] = u0; i_src[l][1] = s1; i_use[l][1] = u1;
  endtask

  task automatic compare_all(input string tag);
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < NSRC; s++)
        chk($sformatf("%s sel l%0d s%0d", tag, l, s), dut_sel(l, s), exp_sel(l, s));
    chk({tag, " stall"}, 32'(stall_o), 32'(exp_stall()));
  endtask

  // One clock: check at the falling edge, then advance the model with the DUT.
  task automatic step(input string tag);
    bit st;
    apply();
    @(negedge clk);
    compare_all(tag);
    st = exp_stall();
    @(posedge clk);
    model_clock(st);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; adv_i = 1'b0; flush_i = 1'b0;
    clear_id(); apply(); model_reset();
    #12;
    chk("reset sel", 32'(fwd_sel_o), 0);
    chk("reset stall", 32'(stall_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Mid-operation reset with a live forward and a live stall
    adv_i = 1'b1;
    clear_id(); set_lane(0, 1, 0, 3, 0, 0, 0, 0); set_lane(1, 1, 1, 4, 0, 0, 0, 0); step("rstA");
    clear_id(); set_lane(0, 0, 0, 0, 3, 1, 0, 0); set_lane(1, 1, 1, 4, 0, 0, 0, 0); step("rstB");
    clear_id(); set_lane(0, 0, 0, 0, 4, 1, 0, 0); apply(); #1;
    chk("pre-reset sel", dut_sel(0, 0), 1);
    chk("pre-reset stall", 32'(stall_o), 1);
    rst_n = 1'b0; #1;
    chk("async reset sel", 32'(fwd_sel_o), 0);
    chk("async reset stall", 32'(stall_o), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    clear_id();
    for (int i = 0; i < 3; i++) step("post-reset");
    chk("post-reset idle sel", 32'(fwd_sel_o), 0);

    // ALU to ALU: EX/MEM then MEM/WB forwarding
    clear_id(); set_lane(0, 1, 0, 3, 0, 0, 0, 0); step("aluA");
    clear_id(); set_lane(1, 0, 0, 0, 3, 1, 0, 0); step("aluB");
    chk("alu exmem sel", dut_sel(1, 0), 1);
    clear_id(); set_lane(0, 0, 0, 0, 1, 1, 3, 1); step("aluC");
    chk("alu memwb sel", dut_sel(0, 1), 3);

    // Same-stage priority: higher lane wins
    clear_id(); set_lane(0, 1, 0, 5, 0, 0, 0, 0); set_lane(1, 1, 0, 5, 0, 0, 0, 0); step("prioA");
    clear_id(); set_lane(0, 0, 0, 0, 5, 1, 0, 0); step("prioB");
    chk("prio sel", dut_sel(0, 0), 2);

    // Load-use: one stalled advance, bubble, then MEM/WB of lane 1
    clear_id(); set_lane(1, 1, 1, 2, 0, 0, 0, 0); step("luA");
    clear_id(); set_lane(0, 0, 0, 0, 2, 1, 0, 0); apply(); #1;
    chk("lu stall asserted", 32'(stall_o), 1);
    step("luB1");
    chk("lu bubble stall", 32'(stall_o), 0);
    chk("lu bubble sel", dut_sel(0, 0), 0);
    step("luB2");
    chk("lu wb sel", dut_sel(0, 0), 4);

    // r0 never matches; unused source never matches
    clear_id(); set_lane(0, 1, 0, 0, 0, 0, 0, 0); set_lane(1, 1, 0, 7, 0, 0, 0, 0); step("r0A");
    clear_id(); set_lane(0, 0, 0, 0, 0, 1, 0, 1); set_lane(1, 0, 0, 0, 0, 1, 7, 0); step("r0B");
    chk("r0 sel", dut_sel(0, 0), 0);
    chk("unused sel", dut_sel(1, 1), 0);

    // Hold with a pending stall, then flush
    clear_id(); set_lane(1, 1, 0, 6, 0, 0, 0, 0); set_lane(0, 1, 1, 4, 0, 0, 0, 0); step("flA");
    clear_id(); set_lane(0, 0, 0, 0, 6, 1, 0, 0); step("flB");
    clear_id(); set_lane(1, 0, 0, 0, 0, 0, 4, 1);
    adv_i = 1'b0;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold sel", dut_sel(0, 0), 2);
    chk("hold stall", 32'(stall_o), 0);
    flush_i = 1'b1; step("flush");
    flush_i = 1'b0;
    chk("post-flush sel", 32'(fwd_sel_o), 0);
    adv_i = 1'b1; clear_id(); set_lane(0, 0, 0, 0, 6, 1, 0, 0); step("post-flush");

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      adv_i   = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      clear_id();
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 4) != 0)
          set_lane(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 4),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      step("rnd");
      if (n == 400) begin
        rst_n = 1'b0; #1;
        chk("rnd reset sel", 32'(fwd_sel_o), 0);
        chk("rnd reset stall", 32'(stall_o), 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
